// File: rtl/divf_credit_pipe.sv
// divf_credit_pipe: handshake shell around an external fixed-latency FP divider.
// The lhs and rhs operands are joined, and one op can be issued per cycle.
// The core is never stalled. A credit counter (used_q) reserves a result FIFO
// slot for every op from issue to pop, so the FIFO cannot overflow even while
// the consumer holds result_ready low.
// Optional feature macro: DIVF_DBZ_FLAG_EN adds the result_dbz side-band flag
// (the divisor was +/-0). That flag travels alongside the result.
module divf_credit_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 8,
  parameter int FIFO_DEPTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] lhs,
  input  logic                  lhs_valid,
  output logic                  lhs_ready,
  input  logic [DATA_WIDTH-1:0] rhs,
  input  logic                  rhs_valid,
  output logic                  rhs_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  input  logic                  result_ready,
`ifdef DIVF_DBZ_FLAG_EN
  output logic                  result_dbz,
`endif
  output logic [DATA_WIDTH-1:0] core_x,
  output logic [DATA_WIDTH-1:0] core_y,
  output logic                  core_ce,
  input  logic [DATA_WIDTH-1:0] core_r
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int UW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [PW-1:0] ONE_P    = PW'(1);
  localparam logic [UW-1:0] DEPTH_U  = UW'(FIFO_DEPTH);
  localparam logic [UW-1:0] ONE_U    = UW'(1);

  logic [UW-1:0]         used_q, used_d;
  logic [UW-1:0]         count_q, count_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [LATENCY-1:0]    vld_pipe_q, vld_pipe_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic credit_ok_s;
  logic fire_s;
  logic pop_s;
  logic wr_en_s;
  logic result_valid_s;

  // Credit is derived from registered state only. A pop frees its slot one cycle later.
  assign credit_ok_s    = (used_q < DEPTH_U);
  assign fire_s         = lhs_valid & rhs_valid & credit_ok_s;
  assign result_valid_s = (count_q != '0);
  assign pop_s          = result_valid_s & result_ready;
  assign wr_en_s        = vld_pipe_q[LATENCY-1];

  // Readies and the core enable are forced low while reset is held.
  assign lhs_ready    = rhs_valid & credit_ok_s & rst;
  assign rhs_ready    = lhs_valid & credit_ok_s & rst;
  assign core_ce      = rst;
  assign core_x       = lhs;
  assign core_y       = rhs;
  assign result       = mem_q[rd_ptr_q];
  assign result_valid = result_valid_s;

  // Next-state logic for the valid shift register, the pointers and the counters.
  always_comb begin
    vld_pipe_d    = vld_pipe_q << 1;
    vld_pipe_d[0] = fire_s;

    wr_ptr_d = wr_ptr_q;
    if (wr_en_s) begin
      if (wr_ptr_q == LAST_PTR) begin
        wr_ptr_d = '0;
      end else begin
        wr_ptr_d = wr_ptr_q + ONE_P;
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    rd_ptr_d = rd_ptr_q;
    if (pop_s) begin
      if (rd_ptr_q == LAST_PTR) begin
        rd_ptr_d = '0;
      end else begin
        rd_ptr_d = rd_ptr_q + ONE_P;
      end
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    used_d = used_q;
    case ({fire_s, pop_s})
      2'b10:   used_d = used_q + ONE_U;
      2'b01:   used_d = used_q - ONE_U;
      default: used_d = used_q;
    endcase

    count_d = count_q;
    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + ONE_U;
      2'b01:   count_d = count_q - ONE_U;
      default: count_d = count_q;
    endcase
  end

  // Control state register. Reset discards every in-flight and stored result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      used_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      vld_pipe_q <= '0;
    end else begin
      used_q     <= used_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  // Result storage captures the core output when its tagged op emerges. It is never cleared.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= core_r;
    end
  end

`ifdef DIVF_DBZ_FLAG_EN
  logic [LATENCY-1:0] dbz_pipe_q, dbz_pipe_d;
  logic               mem_dbz_q [FIFO_DEPTH];
  logic               dbz_s;

  assign dbz_s      = (rhs[DATA_WIDTH-2:0] == '0);
  assign result_dbz = result_valid_s & mem_dbz_q[rd_ptr_q];

  // The divide-by-zero flag shifts in lockstep with vld_pipe.
  always_comb begin
    dbz_pipe_d    = dbz_pipe_q << 1;
    dbz_pipe_d[0] = dbz_s;
  end

  // Side-band shift register for the flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbz_pipe_q <= '0;
    end else begin
      dbz_pipe_q <= dbz_pipe_d;
    end
  end

  // Extra FIFO bit written alongside the quotient.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_dbz_q[wr_ptr_q] <= dbz_pipe_q[LATENCY-1];
    end
  end
`endif

endmodule

// File: tb/tb_divf_credit_pipe.sv
// Testbench for divf_credit_pipe.
// The bench supplies a toy fixed-latency core whose function is exact for
// power-of-two operands. A queue model tracks the issued ops: the results must
// leave in order, each LATENCY+1 cycles after issue, and the credit is the
// count of ops that are outstanding.
module tb_divf_credit_pipe;
  localparam int W = 32;
  localparam int L = 8;
  localparam int D = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W-1:0] lhs, rhs, result, core_x, core_y, core_r;
  logic         lhs_valid, rhs_valid, result_ready;
  logic         lhs_ready, rhs_ready, result_valid, core_ce;
`ifdef DIVF_DBZ_FLAG_EN
  logic         result_dbz;
`endif

  divf_credit_pipe #(.DATA_WIDTH(W), .LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .lhs(lhs), .lhs_valid(lhs_valid), .lhs_ready(lhs_ready),
    .rhs(rhs), .rhs_valid(rhs_valid), .rhs_ready(rhs_ready),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
`ifdef DIVF_DBZ_FLAG_EN
    .result_dbz(result_dbz),
`endif
    .core_x(core_x), .core_y(core_y), .core_ce(core_ce), .core_r(core_r)
  );

  // Toy divider: sign xor, exponent difference, mantissa xor (exact for powers of two).
  function automatic logic [W-1:0] core_fn(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [7:0] e;
    e = x[30:23] - y[30:23] + 8'd127;
    return {x[31] ^ y[31], e, x[22:0] ^ y[22:0]};
  endfunction

  logic [W-1:0] cpipe [L];
  always @(posedge clk) begin
    if (core_ce) begin
      cpipe[0] <= core_fn(core_x, core_y);
      for (int i = 1; i < L; i++) cpipe[i] <= cpipe[i-1];
    end
  end
  assign core_r = cpipe[L-1];

  int errs = 0, checks = 0, cyc = 0, n_fires = 0, n_pops = 0, n_stall = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  typedef struct {
    logic [W-1:0] v;
    logic         z;
    int           avail;
  } exp_t;
  exp_t q[$];

  // One compare process: every cycle, check the outputs against the queue model, then advance the model.
  always @(negedge clk) begin : cmp
    logic credit, ev, fire, pop;
    exp_t e;
    cyc++;
    if (!rst) begin
      q.delete();
      chk("rst_lhs_ready", lhs_ready, 0);
      chk("rst_rhs_ready", rhs_ready, 0);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_core_ce", core_ce, 0);
`ifdef DIVF_DBZ_FLAG_EN
      chk("rst_result_dbz", result_dbz, 0);
`endif
    end else begin
      credit = (q.size() < D);
      ev     = (q.size() > 0) && (q[0].avail <= cyc);
      chk("lhs_ready", lhs_ready, rhs_valid & credit);
      chk("rhs_ready", rhs_ready, lhs_valid & credit);
      chk("core_ce", core_ce, 1);
      chk("core_x", core_x, lhs);
      chk("core_y", core_y, rhs);
      chk("result_valid", result_valid, ev);
      if (ev) begin
        chk("result", result, q[0].v);
`ifdef DIVF_DBZ_FLAG_EN
        chk("result_dbz", result_dbz, q[0].z);
`endif
      end
      if (lhs_valid && rhs_valid && !lhs_ready) n_stall++;
      fire = lhs_valid & rhs_valid & credit;
      pop  = ev & result_ready;
      if (pop) begin
        void'(q.pop_front());
        n_pops++;
      end
      if (fire) begin
        e.v     = core_fn(lhs, rhs);
        e.z     = (rhs[W-2:0] == '0);
        e.avail = cyc + L + 1;
        q.push_back(e);
        n_fires++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int f0, p0, s0;

  initial begin
    rst = 1'b0; lhs = '0; rhs = '0;
    lhs_valid = 1'b1; rhs_valid = 1'b1; result_ready = 1'b0;
    step(3);
    chk("hold_rst_lhs_ready", lhs_ready, 0);
    chk("hold_rst_result_valid", result_valid, 0);
    lhs_valid = 1'b0; rhs_valid = 1'b0;
    rst = 1'b1;
    step(1);

    // A single op, 4.0 / 2.0, gives 2.0 exactly LATENCY+1 cycles after it fires.
    lhs = 32'h40800000; rhs = 32'h40000000;
    lhs_valid = 1'b1; rhs_valid = 1'b1; result_ready = 1'b1;
    #1;
    chk("t1_lhs_ready", lhs_ready, 1);
    step(1);
    lhs_valid = 1'b0; rhs_valid = 1'b0;
    step(L - 1);
    chk("t1_not_yet_valid", result_valid, 0);
    step(1);
    chk("t1_valid", result_valid, 1);
    chk("t1_result", result, 32'h40000000);
    step(2);

    // Stream 32 ops with result_ready held high: no stall, and 32 results.
    f0 = n_fires; p0 = n_pops; s0 = n_stall;
    lhs_valid = 1'b1; rhs_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      lhs = $urandom; rhs = $urandom;
      step(1);
    end
    lhs_valid = 1'b0; rhs_valid = 1'b0;
    chk("stream_fires", n_fires - f0, 32);
    chk("stream_stalls", n_stall - s0, 0);
    step(L + 4);
    chk("stream_pops", n_pops - p0, 32);
    chk("stream_drained", result_valid, 0);

    // Backpressure: exactly FIFO_DEPTH ops fire, then the readies drop.
    result_ready = 1'b0;
    f0 = n_fires; p0 = n_pops;
    lhs_valid = 1'b1; rhs_valid = 1'b1;
    for (int i = 0; i < D + 6; i++) begin
      lhs = $urandom; rhs = $urandom;
      step(1);
    end
    chk("bp_fires", n_fires - f0, D);
    chk("bp_lhs_ready_low", lhs_ready, 0);
    chk("bp_rhs_ready_low", rhs_ready, 0);
    result_ready = 1'b1;
    #1;
    chk("bp_ready_low_in_pop_cycle", lhs_ready, 0);
    step(1);
    chk("bp_ready_after_pop", lhs_ready, 1);
    for (int i = 0; i < 6; i++) begin
      lhs = $urandom; rhs = $urandom;
      step(1);
    end
    lhs_valid = 1'b0; rhs_valid = 1'b0;
    step(L + D + 4);
    chk("bp_no_loss", n_pops - p0, n_fires - f0);
    chk("bp_drained", result_valid, 0);

    // Join: lhs alone never fires; the single fire happens once rhs arrives.
    f0 = n_fires;
    lhs_valid = 1'b1; rhs_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      lhs = $urandom;
      #1;
      chk("join_lhs_ready", lhs_ready, 0);
      step(1);
    end
    chk("join_no_fire", n_fires - f0, 0);
    rhs = 32'h3F800000; rhs_valid = 1'b1;
    step(1);
    lhs_valid = 1'b0; rhs_valid = 1'b0;
    chk("join_one_fire", n_fires - f0, 1);
    step(L + 3);

    // Reset with 2 results stored and LATENCY/2 ops in flight.
    result_ready = 1'b0;
    lhs_valid = 1'b1; rhs_valid = 1'b1;
    lhs = 32'h41000000; rhs = 32'h40000000; step(1);
    lhs = 32'h40400000; rhs = 32'h3F800000; step(1);
    lhs_valid = 1'b0; rhs_valid = 1'b0;
    step(L + 2);
    chk("prerst_stored", result_valid, 1);
    lhs_valid = 1'b1; rhs_valid = 1'b1;
    for (int i = 0; i < L / 2; i++) begin
      lhs = $urandom; rhs = $urandom;
      step(1);
    end
    lhs_valid = 1'b0; rhs_valid = 1'b0;
    p0 = n_pops;
    rst = 1'b0;
    #1;
    chk("rst_immediate_valid", result_valid, 0);
    step(2);
    rst = 1'b1;
    result_ready = 1'b1;
    step(L + 4);
    chk("rst_no_stale_pops", n_pops - p0, 0);
    chk("rst_no_stale_valid", result_valid, 0);

`ifdef DIVF_DBZ_FLAG_EN
    // Divide-by-zero flag: the divisor -0 sets it, and the divisor 1.0 clears it.
    lhs = 32'h3F800000; rhs = 32'h80000000;
    lhs_valid = 1'b1; rhs_valid = 1'b1;
    step(1);
    rhs = 32'h3F800000;
    step(1);
    lhs_valid = 1'b0; rhs_valid = 1'b0;
    step(L - 1);
    chk("dbz_valid", result_valid, 1);
    chk("dbz_set", result_dbz, 1);
    step(1);
    chk("dbz_clear", result_dbz, 0);
    step(3);
`endif

    // Random traffic with random backpressure.
    f0 = n_fires; p0 = n_pops;
    for (int i = 0; i < 400; i++) begin
      lhs = $urandom; rhs = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      lhs_valid = ($urandom_range(0, 3) != 0);
      rhs_valid = ($urandom_range(0, 3) != 0);
      result_ready = ($urandom_range(0, 2) != 0);
      step(1);
    end
    lhs_valid = 1'b0; rhs_valid = 1'b0; result_ready = 1'b1;
    step(L + D + 4);
    chk("rand_no_loss", n_pops - p0, n_fires - f0);
    chk("rand_drained", result_valid, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
